// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Holds the fetch-error filler word, the response FSM states and the requester IDs.
package cpu_pkg;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } fsm_state_t;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_id_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the side that did not win last wins.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[REQ_FETCH] && (!req[REQ_LOAD] || last == REQ_LOAD)) begin
      gnt[REQ_FETCH] = 1'b1;
    end else if (req[REQ_LOAD]) begin
      gnt[REQ_LOAD] = 1'b1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port sync-read instruction memory between CPU fetch and a program loader; fetch latency 1.
// A stalled response (rready low) is parked in a skid register; fetch is not granted until it drains, loads always are.
module imem_arbiter #(
  parameter int          MEM_WORDS = 32,
  parameter logic [31:0] NOP_INSN  = cpu_pkg::NOP_INSN,
  localparam int         AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  input  logic          fetch_rready,
  input  logic          load_req,
  input  logic [31:0]   load_addr,
  input  logic [31:0]   load_wdata,
  output logic          load_gnt,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);
  import cpu_pkg::*;

  fsm_state_t  state, state_nxt;
  req_id_t     last_win;
  logic        err_q;
  logic        skid_err;
  logic [31:0] skid_dat;
  logic        fetch_bad, load_bad, fetch_elig;
  logic [1:0]  req, gnt;

  assign fetch_bad = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> 2) >= 32'(MEM_WORDS));
  assign load_bad  = (load_addr[1:0] != 2'b00) || ((load_addr >> 2) >= 32'(MEM_WORDS));

  // Fetch may only issue when the previous response is being consumed this cycle.
  assign fetch_elig = fetch_req && (state == IDLE || fetch_rready);
  assign req        = {load_req, fetch_elig} & {2{!rst}};

  rr_arbiter2 u_rr (
    .req  (req),
    .last (last_win),
    .gnt  (gnt)
  );

  assign fetch_gnt = gnt[REQ_FETCH];
  assign load_gnt  = gnt[REQ_LOAD];

  // Bad addresses are still granted so the requester sees progress; memory is never touched.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (load_gnt) begin
      mem_en    = !load_bad;
      mem_we    = !load_bad;
      mem_addr  = load_addr[AW+1:2];
      mem_wdata = load_wdata;
    end else if (fetch_gnt) begin
      mem_en   = !fetch_bad;
      mem_addr = fetch_addr[AW+1:2];
    end
  end

  always_comb begin
    state_nxt    = state;
    fetch_rvalid = 1'b0;
    fetch_rdata  = '0;
    fetch_err    = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_gnt) state_nxt = RESP;
      end
      RESP: begin
        fetch_rvalid = 1'b1;
        fetch_rdata  = err_q ? NOP_INSN : mem_rdata;
        fetch_err    = err_q;
        if (!fetch_rready)  state_nxt = HOLD;
        else if (fetch_gnt) state_nxt = RESP;
        else                state_nxt = IDLE;
      end
      HOLD: begin
        fetch_rvalid = 1'b1;
        fetch_rdata  = skid_dat;
        fetch_err    = skid_err;
        if (fetch_rready) state_nxt = fetch_gnt ? RESP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_win <= REQ_FETCH;
      err_q    <= 1'b0;
      skid_dat <= '0;
      skid_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fetch_gnt) begin
        last_win <= REQ_FETCH;
        err_q    <= fetch_bad;
      end else if (load_gnt) begin
        last_win <= REQ_LOAD;
      end
      // Memory output is not held across later cycles, so park the response here.
      if (state == RESP && !fetch_rready) begin
        skid_dat <= fetch_rdata;
        skid_err <= fetch_err;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural sync-read memory attached.
module tb_imem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_gnt, fetch_rvalid, fetch_err, fetch_rready;
  logic [31:0] fetch_addr, fetch_rdata;
  logic        load_req, load_gnt;
  logic [31:0] load_addr, load_wdata;
  logic        mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .fetch_rready(fetch_rready),
    .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata), .load_gnt(load_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic idle_in();
    fetch_req = 1'b0; fetch_addr = '0; fetch_rready = 1'b1;
    load_req = 1'b0; load_addr = '0; load_wdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; fetch_req = 1'b1; load_req = 1'b1; #1;
    checks++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL reset_fetch_gnt: got %b want 0", fetch_gnt); end
    checks++; if (load_gnt !== 1'b0) begin errors++; $display("FAIL reset_load_gnt: got %b want 0", load_gnt); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", fetch_rvalid); end
    checks++; if (fetch_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 00000000", fetch_rdata); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    @(negedge clk);
    idle_in(); rst = 1'b0;
  endtask

  task automatic test_load_fetch();
    @(negedge clk);
    load_req = 1'b1; load_addr = 32'h8; load_wdata = 32'h0050_0093; #1;
    checks++; if ({load_gnt, mem_en, mem_we} !== 3'b111) begin errors++; $display("FAIL lf_load_ctl: got %b want 111", {load_gnt, mem_en, mem_we}); end
    checks++; if (mem_addr !== 5'd2) begin errors++; $display("FAIL lf_load_addr: got %0d want 2", mem_addr); end
    checks++; if (mem_wdata !== 32'h0050_0093) begin errors++; $display("FAIL lf_wdata: got %h want 00500093", mem_wdata); end
    @(negedge clk);
    idle_in(); fetch_req = 1'b1; fetch_addr = 32'h8; #1;
    checks++; if ({fetch_gnt, load_gnt, mem_en, mem_we} !== 4'b1010) begin errors++; $display("FAIL lf_fetch_ctl: got %b want 1010", {fetch_gnt, load_gnt, mem_en, mem_we}); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL lf_fetch_wdata: got %h want 00000000", mem_wdata); end
    checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL lf_early_rvalid: got %b want 0", fetch_rvalid); end
    @(negedge clk);
    idle_in(); #1;
    checks++; if (fetch_rvalid !== 1'b1) begin errors++; $display("FAIL lf_rvalid: got %b want 1", fetch_rvalid); end
    checks++; if (fetch_rdata !== 32'h0050_0093) begin errors++; $display("FAIL lf_rdata: got %h want 00500093", fetch_rdata); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL lf_err: got %b want 0", fetch_err); end
    @(negedge clk); #1;
    checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL lf_idle_rvalid: got %b want 0", fetch_rvalid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h8;
    load_req = 1'b1; load_addr = 32'h10; load_wdata = 32'hA5A5_0001;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      checks++; if ({load_gnt, fetch_gnt} !== exp_g) begin errors++; $display("FAIL rr_cycle%0d {load,fetch}: got %b want %b", i, {load_gnt, fetch_gnt}, exp_g); end
      @(negedge clk);
    end
    idle_in(); #1;
    checks++; if ({fetch_rvalid, fetch_rdata} !== {1'b1, 32'h0050_0093}) begin errors++; $display("FAIL rr_resp: got %b/%h want 1/00500093", fetch_rvalid, fetch_rdata); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [31:0] fa;
    for (int i = 0; i < 2; i++) begin
      fa = (i == 0) ? 32'h6 : 32'h80;
      @(negedge clk);
      fetch_req = 1'b1; fetch_addr = fa; #1;
      checks++; if ({fetch_gnt, mem_en} !== 2'b10) begin errors++; $display("FAIL err_gnt_%h {gnt,mem_en}: got %b want 10", fa, {fetch_gnt, mem_en}); end
      @(negedge clk);
      idle_in(); #1;
      checks++; if ({fetch_rvalid, fetch_err, fetch_rdata} !== {2'b11, 32'h0000_0013}) begin errors++; $display("FAIL err_resp_%h: got %b/%b/%h want 1/1/00000013", fa, fetch_rvalid, fetch_err, fetch_rdata); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL err_mem_en_%h: got %b want 0", fa, mem_en); end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      load_req = 1'b1; load_addr = (i == 0) ? 32'h11 : 32'h90; load_wdata = 32'hDEAD_BEEF; #1;
      checks++; if ({load_gnt, mem_en} !== 2'b10) begin errors++; $display("FAIL bad_load%0d {gnt,mem_en}: got %b want 10", i, {load_gnt, mem_en}); end
    end
    @(negedge clk);
    idle_in(); fetch_req = 1'b1; fetch_addr = 32'h10;
    @(negedge clk);
    idle_in(); #1;
    checks++; if ({fetch_err, fetch_rdata} !== {1'b0, 32'hA5A5_0001}) begin errors++; $display("FAIL bad_load_dropped: got %b/%h want 0/a5a50001", fetch_err, fetch_rdata); end
    @(negedge clk);
  endtask

  task automatic test_hold();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h10; #1;
    checks++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL hold_first_gnt: got %b want 1", fetch_gnt); end
    @(negedge clk);
    fetch_req = 1'b0; fetch_rready = 1'b0; #1;
    checks++; if ({fetch_rvalid, fetch_rdata} !== {1'b1, 32'hA5A5_0001}) begin errors++; $display("FAIL hold_resp: got %b/%h want 1/a5a50001", fetch_rvalid, fetch_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fetch_req = 1'b1; fetch_addr = 32'h0;
      load_req = (i == 0); load_addr = 32'h14; load_wdata = 32'h0BAD_F00D; #1;
      checks++; if (fetch_gnt !== 1'b0) begin errors++; $display("FAIL hold%0d_fetch_gnt: got %b want 0", i, fetch_gnt); end
      checks++; if ({fetch_rvalid, fetch_err, fetch_rdata} !== {2'b10, 32'hA5A5_0001}) begin errors++; $display("FAIL hold%0d_data: got %b/%b/%h want 1/0/a5a50001", i, fetch_rvalid, fetch_err, fetch_rdata); end
      checks++; if ({load_gnt, mem_we} !== {2{i == 0}}) begin errors++; $display("FAIL hold%0d_load: got %b want %b", i, {load_gnt, mem_we}, {2{i == 0}}); end
    end
    @(negedge clk);
    load_req = 1'b0; fetch_rready = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h14; #1;
    checks++; if ({fetch_rvalid, fetch_gnt, fetch_rdata} !== {2'b11, 32'hA5A5_0001}) begin errors++; $display("FAIL hold_release: got %b/%b/%h want 1/1/a5a50001", fetch_rvalid, fetch_gnt, fetch_rdata); end
    @(negedge clk);
    idle_in(); #1;
    checks++; if ({fetch_rvalid, fetch_rdata} !== {1'b1, 32'h0BAD_F00D}) begin errors++; $display("FAIL hold_load_written: got %b/%h want 1/0badf00d", fetch_rvalid, fetch_rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad [3];
    logic [31:0] dd [3];
    ad = '{32'h0, 32'h4, 32'hC};
    dd = '{32'h1111_0000, 32'h2222_0004, 32'h3333_000C};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      load_req = 1'b1; load_addr = ad[i]; load_wdata = dd[i];
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_req = 1'b0; fetch_req = (i < 3); fetch_addr = (i < 3) ? ad[i] : 32'h0; #1;
      if (i < 3) begin
        checks++; if (fetch_gnt !== 1'b1) begin errors++; $display("FAIL b2b%0d_gnt: got %b want 1", i, fetch_gnt); end
      end
      if (i > 0) begin
        checks++; if ({fetch_rvalid, fetch_rdata} !== {1'b1, dd[i-1]}) begin errors++; $display("FAIL b2b%0d_resp: got %b/%h want 1/%h", i, fetch_rvalid, fetch_rdata, dd[i-1]); end
      end
    end
    @(negedge clk);
    idle_in(); #1;
    checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_end_rvalid: got %b want 0", fetch_rvalid); end
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h4;
    @(negedge clk);
    fetch_req = 1'b0; rst = 1'b1; #1;
    checks++; if ({fetch_rvalid, fetch_err, fetch_rdata} !== 34'h0) begin errors++; $display("FAIL rstresp_now: got %b/%b/%h want 0/0/00000000", fetch_rvalid, fetch_err, fetch_rdata); end
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL rstresp_after: got %b want 0", fetch_rvalid); end
    @(negedge clk); #1;
    checks++; if (fetch_rvalid !== 1'b0) begin errors++; $display("FAIL rstresp_stale: got %b want 0", fetch_rvalid); end
    fetch_req = 1'b1; fetch_addr = 32'h4; #1;
    checks++; if ({fetch_gnt, load_gnt} !== 2'b10) begin errors++; $display("FAIL rstresp_next_gnt {fetch,load}: got %b want 10", {fetch_gnt, load_gnt}); end
    @(negedge clk);
    idle_in(); #1;
    checks++; if ({fetch_rvalid, fetch_rdata} !== {1'b1, 32'h2222_0004}) begin errors++; $display("FAIL rstresp_fetch: got %b/%h want 1/22220004", fetch_rvalid, fetch_rdata); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem_rdata = '0;
    rst = 1'b1;
    idle_in();
    repeat (2) @(negedge clk);
    test_reset();
    test_load_fetch();
    test_round_robin();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_in_resp();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 32, giving the instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter NOP_INSN, default 32'h0000_0013, the word returned on an errored fetch.
REQ-003 SHALL derive localparam AW = $clog2(MEM_WORDS), the word-index width.
REQ-004 SHALL have ports clk, input, 1, the single clock, and rst, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have ports fetch_req (in, 1) and fetch_addr (in, 32), a CPU fetch request at a byte address.
REQ-006 SHALL have ports fetch_gnt (out, 1), fetch_rvalid (out, 1), fetch_rdata (out, 32), fetch_err (out, 1) and fetch_rready (in, 1).
REQ-007 SHALL have ports load_req (in, 1), load_addr (in, 32) at a byte address, load_wdata (in, 32) and load_gnt (out, 1), forming the program-loader write port.
REQ-008 SHALL have ports mem_en (out, 1), mem_we (out, 1), mem_addr (out, AW), mem_wdata (out, 32) and mem_rdata (in, 32); the memory is single-port with a synchronous one-cycle read.

Function
REQ-009 SHALL be a three-state FSM with states IDLE, RESP and HOLD: RESP means read data arrives this cycle, HOLD means a response is stalled.
REQ-010 SHALL grant at most one requester per cycle; fetch_gnt and load_gnt are combinational and never asserted together.
REQ-011 SHALL, when both requesters are eligible, arbitrate round-robin with a 1-bit last-winner register; the initial winner after reset is the loader.
REQ-012 SHALL make a fetch eligible only in IDLE, in RESP with fetch_rready=1, or in HOLD with fetch_rready=1.
REQ-013 SHALL make the loader eligible in every state.
REQ-014 SHALL drive mem_en=1 in the granted cycle, with mem_we=1 for a load and 0 for a fetch, and mem_addr = addr[AW+1:2].
REQ-015 SHALL drive mem_wdata from load_wdata during a load and hold it at 0 otherwise.
REQ-016 SHALL raise fetch_rvalid exactly 1 cycle after fetch_gnt, with fetch_rdata = mem_rdata (fetch latency 1).
REQ-017 SHALL treat a fetch as errored if fetch_addr[1:0] != 0 or fetch_addr >> 2 >= MEM_WORDS.
REQ-018 SHALL NOT enable memory for an errored fetch; the response one cycle later is fetch_rdata = NOP_INSN with fetch_err=1.
REQ-019 SHALL acknowledge an out-of-range or misaligned load with load_gnt but keep mem_en=0, so the write is dropped silently.
REQ-020 SHALL, when fetch_rvalid=1 and fetch_rready=0, capture rdata/err into a skid register, enter HOLD and present the captured values stably until fetch_rready=1.
REQ-021 SHALL use these FSM transitions: IDLE->RESP on a fetch grant; RESP->IDLE on rready with no new fetch; RESP->RESP on rready with a new fetch grant (back-to-back, 1 fetch/cycle); RESP->HOLD on !rready.
REQ-022 SHALL use these HOLD transitions: HOLD->RESP on rready with a fetch grant; HOLD->IDLE on rready with no fetch.
REQ-023 SHALL allow a load granted in HOLD without disturbing the held response.
REQ-024 SHALL drive fetch_rvalid low whenever the state is IDLE.

Reset
REQ-025 SHALL, while rst=1, force state=IDLE, fetch_rvalid=0, fetch_err=0, fetch_rdata=0, the skid register to 0 and last-winner=fetch.
REQ-026 SHALL gate off mem_en, fetch_gnt and load_gnt while rst=1.
REQ-027 SHALL, if rst is asserted mid-RESP or mid-HOLD, discard the pending response; no rvalid appears after deassertion.

Structure
REQ-028 SHALL place NOP_INSN, the FSM state enum and the requester-ID enum in shared package cpu_pkg.
REQ-029 SHALL implement the round-robin pick as sub-module rr_arbiter2 (2 requests, 1-bit pointer).

Verification
REQ-030 SHALL cover this directed scenario: load 0x00500093 at byte address 0x8, then fetch 0x8 -> fetch_rvalid one cycle after fetch_gnt with rdata=0x00500093, err=0.
REQ-031 SHALL cover this directed scenario: load_req and fetch_req held together for 4 cycles -> grants alternate L,F,L,F with no cycle granting both.
REQ-032 SHALL cover this directed scenario: fetch 0x6 and, separately, fetch 0x80 with MEM_WORDS=32 -> rdata=0x00000013, err=1, mem_en stays 0.
REQ-033 SHALL cover this directed scenario: fetch_rready=0 for 3 cycles after a response -> rdata stable in HOLD, no fetch_gnt, a concurrent load is granted and written.
REQ-034 SHALL cover this directed scenario: back-to-back fetches 0x0,0x4,0xC with rready=1 -> three consecutive rvalid cycles with matching data.
REQ-035 SHALL cover this directed scenario: rst asserted in the RESP cycle -> rvalid=0 immediately, state IDLE, and the next grant goes to fetch.
